// File: rtl/tickgen_pkg.sv
// tickgen_pkg: shared constants and types for the tick generator.
//   DIV_W_DEFAULT  default divisor/counter width (28 bits)
//   DIV_*          divisors that yield common rates from a 100 MHz clock
//   DIV_INIT_DEF   packed reset divisors, ch3..ch0 (ch0 in the low slice)
//   act_t          per-channel action selected at each clock edge
package tickgen_pkg;

  localparam int DIV_W_DEFAULT = 28;
  localparam int N_CH_DEFAULT  = 4;

  localparam logic [DIV_W_DEFAULT-1:0] DIV_50MHZ = 28'd2;
  localparam logic [DIV_W_DEFAULT-1:0] DIV_25MHZ = 28'd4;
  localparam logic [DIV_W_DEFAULT-1:0] DIV_100HZ = 28'd1000000;
  localparam logic [DIV_W_DEFAULT-1:0] DIV_4HZ   = 28'd25000000;

  localparam logic [N_CH_DEFAULT*DIV_W_DEFAULT-1:0] DIV_INIT_DEF =
    {DIV_4HZ, DIV_100HZ, DIV_50MHZ, DIV_25MHZ};

  // Action taken by a channel at an edge, listed in priority order.
  typedef enum logic [2:0] {
    ACT_RESET = 3'd0,
    ACT_LOAD  = 3'd1,
    ACT_CLEAR = 3'd2,
    ACT_IDLE  = 3'd3,
    ACT_HOLD  = 3'd4,
    ACT_COUNT = 3'd5
  } act_t;

endpackage

// File: rtl/tick_channel.sv
// tick_channel: one divider channel of the tick generator.
// Counts clk edges modulo the divisor; on the last count of a period it
// emits a one-cycle tick and toggles the square output.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   en          channel enable (0 = idle: counter, tick, sq forced low)
//   hold        freeze counter and sq, suppress tick
//   clr         phase-align clear: counter, tick and sq to zero
//   ld, ld_div  divisor load strobe and new divisor
//   tick, sq    registered tick pulse and square output
module tick_channel
  import tickgen_pkg::*;
#(
  parameter int               DIV_W = DIV_W_DEFAULT,
  parameter logic [DIV_W-1:0] INIT  = DIV_25MHZ[DIV_W-1:0]
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hold,
  input  logic             clr,
  input  logic             ld,
  input  logic [DIV_W-1:0] ld_div,
  output logic             tick,
  output logic             sq
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_r;
  logic             wrap;
  act_t             act;

  // Last count of the period; only meaningful when div_r is nonzero, which
  // the idle decode guarantees before counting is ever selected.
  always_comb begin
    wrap = (cnt_r == (div_r - ONE));
  end

  // Priority decode of what this channel does at the next edge.
  always_comb begin
    act = ACT_COUNT;
    if (!rst_n) begin
      act = ACT_RESET;
    end else if (ld) begin
      act = ACT_LOAD;
    end else if (clr) begin
      act = ACT_CLEAR;
    end else if (!en || (div_r == '0)) begin
      act = ACT_IDLE;
    end else if (hold) begin
      act = ACT_HOLD;
    end else begin
      act = ACT_COUNT;
    end
  end

  // Counter, divisor and output registers.
  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET: begin
        cnt_r <= '0;
        div_r <= INIT;
        tick  <= 1'b0;
        sq    <= 1'b0;
      end
      ACT_LOAD: begin
        // sq keeps its level so a retune does not glitch the square wave.
        div_r <= ld_div;
        cnt_r <= '0;
        tick  <= 1'b0;
      end
      ACT_CLEAR, ACT_IDLE: begin
        cnt_r <= '0;
        tick  <= 1'b0;
        sq    <= 1'b0;
      end
      ACT_HOLD: begin
        tick <= 1'b0;
      end
      ACT_COUNT: begin
        if (wrap) begin
          cnt_r <= '0;
          tick  <= 1'b1;
          sq    <= ~sq;
        end else begin
          cnt_r <= cnt_r + ONE;
          tick  <= 1'b0;
        end
      end
      default: begin
        cnt_r <= '0;
        tick  <= 1'b0;
        sq    <= 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/tick_generator.sv
// tick_generator: multi-channel clock-enable generator.
// Each channel divides clk by its own runtime-loadable integer divisor and
// produces a one-cycle tick plus a 50%-duty square output (period 2*div).
// Optional build macro TICKGEN_STEP_EN adds a 'step' input: while paused,
// a cycle with step=1 advances every active channel by exactly one count.
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   pause     global freeze of all channel counters
//   step      (TICKGEN_STEP_EN only) single-count advance while paused
//   sync_clr  clear all counters and square phases together
//   ch_en     per-channel enable
//   div_ld    per-channel divisor load strobe
//   div_in    packed new divisors, channel c in [c*DIV_W +: DIV_W]
//   tick      per-channel registered one-cycle pulse
//   sq        per-channel registered square output
module tick_generator
  import tickgen_pkg::*;
#(
  parameter int                      N_CH     = N_CH_DEFAULT,
  parameter int                      DIV_W    = DIV_W_DEFAULT,
  parameter logic [N_CH*DIV_W-1:0]   DIV_INIT = DIV_INIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pause,
`ifdef TICKGEN_STEP_EN
  input  logic                  step,
`endif
  input  logic                  sync_clr,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       div_ld,
  input  logic [N_CH*DIV_W-1:0] div_in,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       sq
);

  logic hold;

  // A step pulse lets one count through while paused.
  always_comb begin
`ifdef TICKGEN_STEP_EN
    hold = pause & ~step;
`else
    hold = pause;
`endif
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    tick_channel #(
      .DIV_W (DIV_W),
      .INIT  (DIV_INIT[c*DIV_W +: DIV_W])
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (ch_en[c]),
      .hold   (hold),
      .clr    (sync_clr),
      .ld     (div_ld[c]),
      .ld_div (div_in[c*DIV_W +: DIV_W]),
      .tick   (tick[c]),
      .sq     (sq[c])
    );
  end

endmodule
